mul_share_arbiter: RTL and testbench

//  Shares one combinational 8-bit multiplier (multiplier_8bit) among NUM_REQ requesters.
//  - Round-robin arbitration; valid/ready handshake on the request side.
//  - Operands are registered, then held for MUL_LAT cycles of settle time.
//  - The product is returned with the requester ID on a valid/ready response port.
//  - Sits between ALU/address-gen clients and the shared multiplier datapath.

---
 rtl/mul_arb_pkg.sv | 13 +
 rtl/mul_rr_pick.sv | 31 +++
 rtl/multiplier_8bit.sv | 13 +
 rtl/mul_share_arbiter.sv | 105 ++++++++++
 tb/tb_mul_share_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_arb_pkg.sv
// Shared constants and the FSM state type for the shared-multiplier arbiter.
package mul_arb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mul_rr_pick.sv
// Round-robin picker: first requester with req set, scanning from last+1 with wrap.
module mul_rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] pos;

  // Walk the N positions after last; the first set request wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    pos        = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = IW'((32'(last) + k) % N);
      if (!any && req[pos]) begin
        any             = 1'b1;
        gnt_onehot[pos] = 1'b1;
        gnt_idx         = pos;
      end
    end
  end

endmodule

// File: rtl/multiplier_8bit.sv
// Combinational 8x8 multiplier; the product is truncated to the low 8 bits.
module multiplier_8bit
  import mul_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] product
);

  // Self-determined 8-bit multiply drops everything above bit 7.
  assign product = a * b;

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one combinational multiplier among NUM_REQ requesters, round-robin,
// with a valid/ready response port carrying the product and requester id.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned MUL_LAT = 1,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_product,
  input  logic                      resp_ready,
  output logic                      busy,
  output logic [15:0]               op_count
);

  state_t              state;
  logic [DATA_W-1:0]   a_q, b_q, prod_q, mul_p;
  logic [ID_W-1:0]     id_q, last_grant, gnt_idx;
  logic [NUM_REQ-1:0]  gnt_onehot;
  logic                gnt_any;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   a_arr [NUM_REQ];
  logic [DATA_W-1:0]   b_arr [NUM_REQ];

  // Unpack the flat operand buses into per-requester lanes.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign a_arr[i] = req_a[i*DATA_W +: DATA_W];
    assign b_arr[i] = req_b[i*DATA_W +: DATA_W];
  end

  mul_rr_pick #(.N(NUM_REQ)) u_pick (
    .req        (req_valid),
    .last       (last_grant),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  multiplier_8bit u_mul (
    .a       (a_q),
    .b       (b_q),
    .product (mul_p)
  );

  // Grant is same-cycle and only offered while idle and out of reset.
  assign req_ready    = (rst_n && state == IDLE) ? gnt_onehot : '0;
  assign resp_id      = id_q;
  assign resp_product = prod_q;

  // Arbitration FSM with operand, result, settle-counter and op-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      id_q       <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      cnt        <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            a_q        <= a_arr[gnt_idx];
            b_q        <= b_arr[gnt_idx];
            id_q       <= gnt_idx;
            last_grant <= gnt_idx;
            cnt        <= CNT_W'(MUL_LAT);
            busy       <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            prod_q     <= mul_p;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            op_count   <= op_count + 16'd1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: one instance at MUL_LAT=1, one at MUL_LAT=3.
module tb_mul_share_arbiter;

  logic        clk;
  logic        rst_n;

  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic        resp_valid, resp_ready, busy;
  logic [1:0]  resp_id;
  logic [7:0]  resp_product;
  logic [15:0] op_count;

  logic [3:0]  req_valid3, req_ready3;
  logic [31:0] req_a3, req_b3;
  logic        resp_valid3, resp_ready3, busy3;
  logic [1:0]  resp_id3;
  logic [7:0]  resp_product3;
  logic [15:0] op_count3;

  int n_checks;
  int n_fail;

  mul_share_arbiter #(.NUM_REQ(4), .MUL_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_product(resp_product),
    .resp_ready(resp_ready), .busy(busy), .op_count(op_count)
  );

  mul_share_arbiter #(.NUM_REQ(4), .MUL_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3), .req_ready(req_ready3),
    .resp_valid(resp_valid3), .resp_id(resp_id3), .resp_product(resp_product3),
    .resp_ready(resp_ready3), .busy(busy3), .op_count(op_count3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input int r, input logic [7:0] a, input logic [7:0] b);
    req_a[r*8 +: 8] = a;
    req_b[r*8 +: 8] = b;
  endtask

  // Single-requester operation on the MUL_LAT=1 instance, bounded wait for the response.
  task automatic run_op(input int r, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] p, input string tag);
    bit seen;
    set_ops(r, a, b);
    req_valid  = 4'(1 << r);
    resp_ready = 1'b1;
    #1;
    check({tag, "_gnt"}, 32'(req_ready), 32'(1 << r));
    tick;
    req_valid = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
    check({tag, "_resp_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_id"},   32'(resp_id),      32'(r));
      check({tag, "_prod"}, 32'(resp_product), 32'(p));
    end
    tick;
    resp_ready = 1'b0;
  endtask

  initial begin
    int exp_order [6];
    int g;
    bit seen;
    exp_order = '{0, 1, 2, 3, 0, 1};
    n_checks = 0;
    n_fail   = 0;

    rst_n       = 1'b0;
    req_valid   = '0; req_a  = '0; req_b  = '0; resp_ready  = 1'b0;
    req_valid3  = '0; req_a3 = '0; req_b3 = '0; resp_ready3 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_resp_valid", 32'(resp_valid),   32'd0);
    check("rst_busy",       32'(busy),         32'd0);
    check("rst_op_count",   32'(op_count),     32'd0);
    check("rst_product",    32'(resp_product), 32'd0);
    check("rst_id",         32'(resp_id),      32'd0);
    check("rst_ready",      32'(req_ready),    32'd0);
    rst_n = 1'b1;

    // Request that drops before the edge latches nothing
    req_valid = 4'b0100;
    #1;
    check("drop_gnt", 32'(req_ready), 32'h4);
    req_valid = 4'b0000;
    tick;
    check("drop_busy", 32'(busy), 32'd0);

    // Test 1: 12*11 on req0, then resp_ready held low for 5 cycles
    set_ops(0, 8'd12, 8'd11);
    req_valid = 4'b0001;
    #1;
    check("t1_gnt", 32'(req_ready), 32'h1);
    tick;
    req_valid = 4'b0000;
    check("t1_calc_valid", 32'(resp_valid), 32'd0);
    check("t1_calc_busy",  32'(busy),       32'd1);
    check("t1_calc_ready", 32'(req_ready),  32'd0);
    tick;
    check("t1_valid", 32'(resp_valid),   32'd1);
    check("t1_id",    32'(resp_id),      32'd0);
    check("t1_prod",  32'(resp_product), 32'h84);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("t4_hold_valid", 32'(resp_valid),   32'd1);
      check("t4_hold_id",    32'(resp_id),      32'd0);
      check("t4_hold_prod",  32'(resp_product), 32'h84);
      check("t4_hold_ready", 32'(req_ready),    32'd0);
      check("t4_hold_busy",  32'(busy),         32'd1);
    end
    req_valid  = 4'b0000;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    check("t1_done_valid", 32'(resp_valid), 32'd0);
    check("t1_done_busy",  32'(busy),       32'd0);
    check("t1_op_count",   32'(op_count),   32'd1);

    // Test 2: overflow cases and another id
    run_op(1, 8'd16,  8'd17,  8'h10, "t2_16x17");
    run_op(2, 8'd200, 8'd3,   8'h58, "t2_200x3");
    run_op(3, 8'd255, 8'd255, 8'h01, "t2_255x255");
    check("t2_op_count", 32'(op_count), 32'd4);

    // Test 3: all requesters valid, grant order 0,1,2,3,0,1, one grant per 3 cycles
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 2), 8'(i + 3));
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      g = exp_order[k];
      check("t3_gnt", 32'(req_ready), 32'(1 << g));
      tick;
      check("t3_calc_ready", 32'(req_ready), 32'd0);
      tick;
      check("t3_valid", 32'(resp_valid),   32'd1);
      check("t3_id",    32'(resp_id),      32'(g));
      check("t3_prod",  32'(resp_product), 32'((g + 2) * (g + 3)));
      tick;
    end
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
    check("t3_op_count", 32'(op_count), 32'd10);

    // Test 5: reset during CALC discards the op and restarts round-robin at req0
    set_ops(1, 8'd9, 8'd9);
    req_valid = 4'b0010;
    #1;
    check("t5_gnt", 32'(req_ready), 32'h2);
    tick;
    check("t5_calc_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy",     32'(busy),         32'd0);
    check("t5_rst_valid",    32'(resp_valid),   32'd0);
    check("t5_rst_ready",    32'(req_ready),    32'd0);
    check("t5_rst_prod",     32'(resp_product), 32'd0);
    check("t5_rst_id",       32'(resp_id),      32'd0);
    check("t5_rst_op_count", 32'(op_count),     32'd0);
    tick;
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    resp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (resp_valid) seen = 1'b1;
    end
    check("t5_no_resp", 32'(seen), 32'd0);
    resp_ready = 1'b0;
    set_ops(0, 8'd3, 8'd4);
    set_ops(2, 8'd5, 8'd6);
    req_valid = 4'b0101;
    #1;
    check("t5_regnt", 32'(req_ready), 32'h1);
    tick;
    req_valid = 4'b0000;
    tick;
    check("t5_valid", 32'(resp_valid),   32'd1);
    check("t5_id",    32'(resp_id),      32'd0);
    check("t5_prod",  32'(resp_product), 32'd12);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    check("t5_op_count", 32'(op_count), 32'd1);

    // Test 6: MUL_LAT=3 latency and op_count wrap from 0xFFFF
    force u_dut3.op_count = 16'hFFFF;
    #1;
    release u_dut3.op_count;
    #1;
    check("t6_preload", 32'(op_count3), 32'hFFFF);
    @(negedge clk);
    req_a3[7:0] = 8'd7;
    req_b3[7:0] = 8'd9;
    req_valid3  = 4'b0001;
    resp_ready3 = 1'b1;
    #1;
    check("t6_gnt", 32'(req_ready3), 32'h1);
    tick;
    req_valid3 = 4'b0000;
    check("t6_busy",       32'(busy3),       32'd1);
    check("t6_t1_valid",   32'(resp_valid3), 32'd0);
    check("t6_calc_count", 32'(op_count3),   32'hFFFF);
    tick;
    check("t6_t2_valid", 32'(resp_valid3), 32'd0);
    tick;
    check("t6_t3_valid", 32'(resp_valid3), 32'd0);
    tick;
    check("t6_t4_valid", 32'(resp_valid3),   32'd1);
    check("t6_id",       32'(resp_id3),      32'd0);
    check("t6_prod",     32'(resp_product3), 32'd63);
    tick;
    resp_ready3 = 1'b0;
    check("t6_wrap",       32'(op_count3),   32'd0);
    check("t6_done_valid", 32'(resp_valid3), 32'd0);
    check("t6_done_busy",  32'(busy3),       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
